// File: rtl/cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// cacheline_adaptor
//
// Bridges the cache's full-line physical-memory port to a burst-oriented main
// memory. A line read is gathered from BEATS narrow beats into a line buffer.
// A line write is latched whole and then streamed out one beat at a time.
// When the whole line has transferred, a single-cycle resp_o goes back to the
// cache. Beat 0 is always the least-significant slice of the line.
//
// Ports:
//   clk        clock; all state updates on its rising edge
//   rst        synchronous, active-low reset
//   line_i     write line from the cache
//   line_o     most recently assembled read line, to the cache
//   address_i  line address from the cache
//   read_i     cache line read request, held until resp_o
//   write_i    cache line write request, held until resp_o
//   resp_o     one-cycle pulse when the line transfer has finished
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   address_o  latched address to memory
//   read_o     burst read request to memory
//   write_o    burst write request to memory
//   resp_i     memory has accepted a write beat or supplied a read beat
//
// Optional build macro CACHELINE_ADAPTOR_ALIGN_EN: when it is defined, the
// low OFFS bits of address_o read as zero, so memory always sees a
// line-aligned address. When it is undefined, address_o is the latched
// address unmodified.
// ---------------------------------------------------------------------------
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS  = LINE_W / BURST_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFS   = $clog2(LINE_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   rd_line_q, rd_line_d;
  logic [LINE_W-1:0]   wr_line_q, wr_line_d;

  // The write line has its own buffer. Because of that, line_o keeps showing
  // the last completed read line across any writes that happen in between.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    rd_line_d = rd_line_q;
    wr_line_d = wr_line_q;

    unique case (state_q)
      IDLE: begin
        // A write takes priority over a read, so a dirty writeback goes out
        // before the refill.
        if (write_i) begin
          addr_d    = address_i;
          wr_line_d = line_i;
          beat_d    = '0;
          state_d   = WRITE;
        end else if (read_i) begin
          addr_d  = address_i;
          beat_d  = '0;
          state_d = READ;
        end
      end

      READ: begin
        if (resp_i) begin
          rd_line_d[int'(beat_q)*BURST_W +: BURST_W] = burst_i;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      WRITE: begin
        if (resp_i) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      rd_line_q <= '0;
      wr_line_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      rd_line_q <= rd_line_d;
      wr_line_q <= wr_line_d;
    end
  end

  // Every memory-side output is decoded from registered state only. No
  // combinational path runs from resp_i to any of them.
  always_comb begin
    read_o  = (state_q == READ);
    write_o = (state_q == WRITE);
    resp_o  = (state_q == DONE);
    line_o  = rd_line_q;
    burst_o = '0;
    if (state_q == WRITE) begin
      burst_o = wr_line_q[int'(beat_q)*BURST_W +: BURST_W];
    end
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    address_o = {addr_q[ADDR_W-1:OFFS], {OFFS{1'b0}}};
`else
    address_o = addr_q;
`endif
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// ---------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Directed, self-checking bench for cacheline_adaptor with the default
// parameters (256-bit line, 64-bit beats, 32-bit address). Inputs are driven
// and outputs sampled 1 ns after each rising clock edge. Every expected value
// is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int assertCount;
  int failCount;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the per-cycle cache/memory handshake inputs
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic rsp, input logic [63:0] bst);
    read_i  = rd;
    write_i = wr;
    resp_i  = rsp;
    burst_i = bst;
  endtask

  // One comparison
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [63:0]  rdData  [4];
  logic [63:0]  wrData  [4];
  logic [63:0]  rdData2 [4];
  logic [63:0]  rdData3 [4];
  logic [255:0] line1;
  logic [255:0] lineRd2;
  logic [255:0] lineRd3;
  logic [255:0] lineW3;
  logic [255:0] lineW5;
  logic [31:0]  expAddr1;
  logic         respPat [7];
  logic [63:0]  burstExp [7];

  initial begin
    assertCount = 0;
    failCount   = 0;

    rdData[0] = 64'h1111_1111_1111_1111;
    rdData[1] = 64'h2222_2222_2222_2222;
    rdData[2] = 64'h3333_3333_3333_3333;
    rdData[3] = 64'h4444_4444_4444_4444;
    line1 = {rdData[3], rdData[2], rdData[1], rdData[0]};

    wrData[0] = 64'hD0D0_D0D0_D0D0_D0D0;
    wrData[1] = 64'hD1D1_D1D1_D1D1_D1D1;
    wrData[2] = 64'hD2D2_D2D2_D2D2_D2D2;
    wrData[3] = 64'hD3D3_D3D3_D3D3_D3D3;

    rdData2[0] = 64'h0123_4567_89AB_CDEF;
    rdData2[1] = 64'hFEDC_BA98_7654_3210;
    rdData2[2] = 64'hAAAA_5555_AAAA_5555;
    rdData2[3] = 64'h0F0F_F0F0_0F0F_F0F0;
    lineRd2 = {rdData2[3], rdData2[2], rdData2[1], rdData2[0]};

    rdData3[0] = 64'hC000_0000_0000_0000;
    rdData3[1] = 64'hC111_1111_1111_1111;
    rdData3[2] = 64'hC222_2222_2222_2222;
    rdData3[3] = 64'hC333_3333_3333_3333;
    lineRd3 = {rdData3[3], rdData3[2], rdData3[1], rdData3[0]};

    lineW3 = {64'h3333_0000_0000_0003, 64'h3333_0000_0000_0002,
              64'h3333_0000_0000_0001, 64'h3333_0000_0000_0000};
    lineW5 = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
              64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    expAddr1 = 32'h0000_1220;
`else
    expAddr1 = 32'h0000_1234;
`endif

    respPat[0] = 1'b1; burstExp[0] = wrData[0];
    respPat[1] = 1'b0; burstExp[1] = wrData[1];
    respPat[2] = 1'b0; burstExp[2] = wrData[1];
    respPat[3] = 1'b1; burstExp[3] = wrData[1];
    respPat[4] = 1'b1; burstExp[4] = wrData[2];
    respPat[5] = 1'b0; burstExp[5] = wrData[3];
    respPat[6] = 1'b1; burstExp[6] = wrData[3];

    // ---------------- Reset ----------------
    rst       = 1'b0;
    line_i    = '0;
    address_i = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    checkOutput("rst_read_o",    256'(read_o),    256'(0));
    checkOutput("rst_write_o",   256'(write_o),   256'(0));
    checkOutput("rst_resp_o",    256'(resp_o),    256'(0));
    checkOutput("rst_line_o",    line_o,          256'(0));
    checkOutput("rst_burst_o",   256'(burst_o),   256'(0));
    checkOutput("rst_address_o", 256'(address_o), 256'(0));
    rst = 1'b1;

    // ---------------- 1: read, no stalls ----------------
    address_i = 32'h0000_1234;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("t1_address_o", 256'(address_o), 256'(expAddr1));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, rdData[i]);
      checkOutput($sformatf("t1_read_o_beat%0d", i), 256'(read_o), 256'(1));
      checkOutput($sformatf("t1_resp_o_beat%0d", i), 256'(resp_o), 256'(0));
      tick();
    end
    // DONE cycle; a spurious resp_i is driven here as well
    address_i = 32'hFFFF_FFFF;
    checkOutput("t1_resp_o_done", 256'(resp_o), 256'(1));
    checkOutput("t1_read_o_done", 256'(read_o), 256'(0));
    checkOutput("t1_line_o",      line_o,       line1);
    applyStimulus(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    tick();

    // ---------------- 6: spurious resp_i in IDLE ----------------
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6_resp_o_%0d", i),  256'(resp_o),  256'(0));
      checkOutput($sformatf("t6_read_o_%0d", i),  256'(read_o),  256'(0));
      checkOutput($sformatf("t6_write_o_%0d", i), 256'(write_o), 256'(0));
      checkOutput($sformatf("t6_line_o_%0d", i),  line_o,        line1);
      applyStimulus(1'b0, 1'b0, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
      tick();
    end

    // ---------------- 2: write with stalls ----------------
    line_i    = {wrData[3], wrData[2], wrData[1], wrData[0]};
    address_i = 32'h0000_2000;
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    // Input changes after latching must not affect the burst
    line_i    = '1;
    address_i = 32'h0000_9999;
    checkOutput("t2_address_o", 256'(address_o), 256'(32'h0000_2000));
    for (int j = 0; j < 7; j++) begin
      applyStimulus(1'b0, 1'b1, respPat[j], 64'h0);
      checkOutput($sformatf("t2_write_o_%0d", j), 256'(write_o), 256'(1));
      checkOutput($sformatf("t2_burst_o_%0d", j), 256'(burst_o), 256'(burstExp[j]));
      tick();
    end
    checkOutput("t2_write_o_done", 256'(write_o), 256'(0));
    checkOutput("t2_resp_o_done",  256'(resp_o),  256'(1));
    checkOutput("t2_line_o_kept",  line_o,        line1);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("t2_resp_o_idle", 256'(resp_o), 256'(0));

    // ---------------- 3: simultaneous read and write ----------------
    line_i    = lineW3;
    address_i = 32'h0000_3000;
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 64'h0);
      checkOutput($sformatf("t3_write_o_%0d", i), 256'(write_o), 256'(1));
      checkOutput($sformatf("t3_read_o_%0d", i),  256'(read_o),  256'(0));
      checkOutput($sformatf("t3_burst_o_%0d", i), 256'(burst_o),
                  256'({32'h3333_0000, 32'(i)}));
      tick();
    end
    checkOutput("t3_resp_o_done", 256'(resp_o), 256'(1));
    checkOutput("t3_read_o_done", 256'(read_o), 256'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("t3_resp_o_idle", 256'(resp_o), 256'(0));
    checkOutput("t3_read_o_idle", 256'(read_o), 256'(0));

    // ---------------- 4: reset during beat 2 of a read ----------------
    address_i = 32'h0000_4000;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hA0A0_A0A0_A0A0_A0A0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 64'hA1A1_A1A1_A1A1_A1A1);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 64'hA2A2_A2A2_A2A2_A2A2);
    tick();
    checkOutput("t4_read_o",    256'(read_o),    256'(0));
    checkOutput("t4_write_o",   256'(write_o),   256'(0));
    checkOutput("t4_resp_o",    256'(resp_o),    256'(0));
    checkOutput("t4_line_o",    line_o,          256'(0));
    checkOutput("t4_burst_o",   256'(burst_o),   256'(0));
    checkOutput("t4_address_o", 256'(address_o), 256'(0));
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("t4_resp_o_after", 256'(resp_o), 256'(0));
    checkOutput("t4_read_o_after", 256'(read_o), 256'(0));
    address_i = 32'h0000_5000;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("t4_address_o_rd2", 256'(address_o), 256'(32'h0000_5000));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, rdData2[i]);
      checkOutput($sformatf("t4_read_o_%0d", i), 256'(read_o), 256'(1));
      tick();
    end
    checkOutput("t4_resp_o_done", 256'(resp_o), 256'(1));
    checkOutput("t4_line_o_rd2",  line_o,       lineRd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    tick();

    // ---------------- 5: writeback then refill ----------------
    line_i    = lineW5;
    address_i = 32'h0000_6000;
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 64'h0);
      checkOutput($sformatf("t5_burst_o_%0d", i), 256'(burst_o),
                  256'({32'h5555_0000, 32'(i)}));
      tick();
    end
    checkOutput("t5_resp_o_wr", 256'(resp_o), 256'(1));
    // The cache switches to the refill request in the response cycle
    address_i = 32'h0000_7000;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("t5_resp_o_gap",  256'(resp_o),  256'(0));
    checkOutput("t5_read_o_gap",  256'(read_o),  256'(0));
    checkOutput("t5_write_o_gap", 256'(write_o), 256'(0));
    tick();
    checkOutput("t5_read_o_start", 256'(read_o),    256'(1));
    checkOutput("t5_address_o",    256'(address_o), 256'(32'h0000_7000));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, rdData3[i]);
      tick();
    end
    checkOutput("t5_resp_o_rd", 256'(resp_o), 256'(1));
    checkOutput("t5_line_o_rd", line_o,       lineRd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    checkOutput("t5_resp_o_end", 256'(resp_o), 256'(0));
    checkOutput("t5_line_o_end", line_o,       lineRd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache controller/datapath, between the cache's physical-memory port and the burst-oriented main memory.
- Converts one full-line read or write request from the cache into a fixed-length burst of narrower beats, and reassembles read beats into a line.
- Returns a single-cycle response to the cache when the whole line has transferred.
- The cache holds its read/write request asserted until it sees that response.

Parameters:
- LINE_W, 256, cache line width in bits.
- BURST_W, 64, memory beat width in bits; LINE_W must be an integer multiple of BURST_W.
- ADDR_W, 32, byte address width.
- Derived: BEATS = LINE_W/BURST_W (default 4); OFFS = log2(LINE_W/8) (default 5).

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-low reset (rst=0 resets)
- line_i  in  LINE_W  write line from cache
- line_o  out  LINE_W  assembled read line to cache
- address_i  in  ADDR_W  line address from cache
- read_i  in  1  cache line read request
- write_i  in  1  cache line write request
- resp_o  out  1  transfer complete, one-cycle pulse
- burst_i  in  BURST_W  read beat from memory
- burst_o  out  BURST_W  write beat to memory
- address_o  out  ADDR_W  address to memory
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- resp_i  in  1  memory beat accepted/valid

Behaviour:

Reset:
- While rst=0 at posedge: state=IDLE, beat counter=0, line buffer=0, address register=0.
- Outputs while in reset: read_o=0, write_o=0, resp_o=0, line_o=0, burst_o=0, address_o=0.
- Reset mid-transfer discards the in-flight transfer with no resp_o.

States: IDLE, READ, WRITE, DONE.

IDLE:
- Requests are sampled only here.
- write_i=1 -> latch address_i and line_i, beat=0, go WRITE.
- Else read_i=1 -> latch address_i, beat=0, go READ.
- Write wins if both are asserted.

READ:
- read_o=1; address_o is the latched address.
- Each cycle with resp_i=1: line buffer slice [beat*BURST_W +: BURST_W] <= burst_i, beat++.
- resp_i=0 cycles are stalls: no capture, beat holds.
- Go DONE on the cycle that captures beat BEATS-1.

WRITE:
- write_o=1; burst_o = latched line slice [beat*BURST_W +: BURST_W], valid from the first WRITE cycle.
- Each cycle with resp_i=1: beat++.
- Go DONE on the cycle that accepts beat BEATS-1.

DONE:
- read_o=write_o=0, resp_o=1 for exactly one cycle, then go IDLE.
- read_i/write_i are ignored in DONE.

Beat ordering and counter:
- Beat 0 is the least-significant slice.
- Beat counter is log2(BEATS) bits and wraps to 0 at completion.

line_o:
- Continuously shows the line buffer.
- Holds the last completed read line until the next read overwrites it.
- Is not valid mid-read.

Latency, zero-stall memory:
- Read: request in IDLE cycle 0, READ cycles 1..4, resp_o in cycle 5.
- Write: same timing.

Other rules:
- address_o, read_o and write_o are registered/state-decoded with no combinational path from resp_i.
- resp_i outside READ/WRITE is ignored.
- Input changes on address_i, line_i, read_i or write_i after latching have no effect on the transfer.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_ALIGN_EN.
- Defined: address_o[OFFS-1:0] forced to 0, i.e. the latched address is line-aligned.
- Undefined: address_o is the latched address_i unmodified.
- The macro changes no other behaviour.

Test Plan:
1. Read, no stalls: address_i=0x0000_1234, read_i=1; memory returns 64'h1111.., 64'h2222.., 64'h3333.., 64'h4444.. with resp_i=1 for 4 consecutive cycles -> read_o high 4 cycles, resp_o pulses once in cycle 5, line_o = {4444..,3333..,2222..,1111..}; with ALIGN_EN address_o=0x0000_1220, without it 0x0000_1234.
2. Write with stalls: line_i = {D3,D2,D1,D0}, write_i=1, resp_i pattern 1,0,0,1,1,0,1 -> burst_o sequence D0,D1,D1,D1,D2,D3,D3; write_o deasserts after the 4th accepted beat; resp_o one pulse next cycle.
3. Simultaneous read_i=1 and write_i=1 in IDLE -> WRITE taken, write_o=1, read_o=0 throughout, single resp_o.
4. rst=0 asserted during beat 2 of a read -> next cycle all outputs 0, no resp_o; a subsequent read completes normally with a correct line_o.
5. Back-to-back: cache write (dirty writeback) immediately followed by read of another address -> two separate bursts, two resp_o pulses, at least one IDLE cycle between them, line_o holds the read line afterwards.
6. Spurious resp_i=1 while IDLE and in DONE -> no state change, no extra resp_o, line_o unchanged.
